// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the RockWave fetch stage: reset defaults, NOP encoding
// and the fetch FSM state type.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP             = 32'h0000_0013;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register: holds, advances by 4 on an accepted fetch, or
// loads a word-aligned redirect target, with redirect taking priority.
module instruction_fetch_pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else if (jump_en) begin
      pc <= jump_addr & ~XLEN'(3);
    end else if (advance) begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one req/ack instruction-memory transaction per fetch and
// registers the returned word and its PCs for instruction_decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            stall,
  input  logic            jump_en_ex,
  input  logic [XLEN-1:0] jump_addr_ex,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            fetch_valid,
  output logic            fetch_busy
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            pc_advance;

  // A redirect in the same cycle as an ack discards the returned word.
  assign pc_advance = (state == FETCH_BUSY) && imem_ack && !jump_en_ex;
  assign fetch_busy = (state == FETCH_BUSY);

  instruction_fetch_pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .advance   (pc_advance),
    .jump_en   (jump_en_ex),
    .jump_addr (jump_addr_ex),
    .pc        (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_VECTOR;
      inst        <= INST_NOP;
      curr_pc_fd  <= RESET_VECTOR;
      next_pc_fd  <= RESET_VECTOR + XLEN'(4);
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        FETCH_IDLE: begin
          if (phase_fetch && !stall && !jump_en_ex) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= FETCH_BUSY;
          end
        end
        FETCH_BUSY: begin
          if (jump_en_ex) begin
            imem_req <= 1'b0;
            state    <= FETCH_IDLE;
          end else if (imem_ack) begin
            inst        <= imem_rdata;
            curr_pc_fd  <= pc;
            next_pc_fd  <= pc + XLEN'(4);
            fetch_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= FETCH_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= FETCH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed corner cases followed by
// random fetch/redirect/stall traffic checked against a transaction-level model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase_fetch;
  logic        stall;
  logic        jump_en_ex;
  logic [31:0] jump_addr_ex;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] curr_pc_fd;
  logic [31:0] next_pc_fd;
  logic        fetch_valid;
  logic        fetch_busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the PC the next fetch should use and the last delivered word.
  logic [31:0] model_pc;
  logic [31:0] exp_inst;
  logic [31:0] exp_curr;
  logic [31:0] exp_next;

  always #5 clk = ~clk;

  instruction_fetch #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .phase_fetch  (phase_fetch),
    .stall        (stall),
    .jump_en_ex   (jump_en_ex),
    .jump_addr_ex (jump_addr_ex),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .curr_pc_fd   (curr_pc_fd),
    .next_pc_fd   (next_pc_fd),
    .fetch_valid  (fetch_valid),
    .fetch_busy   (fetch_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1ns after the rising edge.
  task automatic applyStimulus(input logic ph, input logic st, input logic je,
                               input logic [31:0] ja, input logic ak, input logic [31:0] rd);
    phase_fetch  = ph;
    stall        = st;
    jump_en_ex   = je;
    jump_addr_ex = ja;
    imem_ack     = ak;
    imem_rdata   = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, "_inst"}, inst, exp_inst);
    checkOutput({tag, "_curr"}, curr_pc_fd, exp_curr);
    checkOutput({tag, "_next"}, next_pc_fd, exp_next);
  endtask

  task automatic modelReset();
    model_pc = 32'h0;
    exp_inst = NOP;
    exp_curr = 32'h0;
    exp_next = 32'h4;
  endtask

  // Full fetch: start, wait `latency` cycles with the request outstanding, ack.
  task automatic doFetch(input int latency, input logic [31:0] word);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("start_req", imem_req, 1);
    checkOutput("start_addr", imem_addr, model_pc);
    checkOutput("start_busy", fetch_busy, 1);
    for (int i = 0; i < latency; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 1'b0, $urandom);
      checkOutput("wait_req", imem_req, 1);
      checkOutput("wait_addr", imem_addr, model_pc);
      checkOutput("wait_busy", fetch_busy, 1);
      checkOutput("wait_valid", fetch_valid, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, word);
    exp_inst = word;
    exp_curr = model_pc;
    exp_next = model_pc + 32'd4;
    model_pc = model_pc + 32'd4;
    checkOutput("ack_valid", fetch_valid, 1);
    checkOutput("ack_req", imem_req, 0);
    checkOutput("ack_busy", fetch_busy, 0);
    checkHeld("ack");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("post_valid", fetch_valid, 0);
    checkHeld("post");
  endtask

  // Fetch abandoned by a redirect, optionally coinciding with an ack.
  task automatic doAbort(input int latency, input logic [31:0] target, input logic ack);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("abort_start_addr", imem_addr, model_pc);
    for (int i = 0; i < latency; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, target, ack, $urandom);
    model_pc = target & 32'hFFFF_FFFC;
    checkOutput("abort_valid", fetch_valid, 0);
    checkOutput("abort_req", imem_req, 0);
    checkOutput("abort_busy", fetch_busy, 0);
    checkHeld("abort");
  endtask

  task automatic doJumpIdle(input logic [31:0] target, input logic ph);
    applyStimulus(ph, 1'b0, 1'b1, target, 1'b0, 32'h0);
    model_pc = target & 32'hFFFF_FFFC;
    checkOutput("jidle_req", imem_req, 0);
    checkOutput("jidle_busy", fetch_busy, 0);
  endtask

  task automatic doStallOrStray(input logic stray_ack);
    applyStimulus(~stray_ack, ~stray_ack, 1'b0, 32'h0, stray_ack, $urandom);
    checkOutput("idle_req", imem_req, 0);
    checkOutput("idle_valid", fetch_valid, 0);
    checkHeld("idle");
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b0;
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", fetch_valid, 0);
    checkOutput("rst_busy", fetch_busy, 0);
    checkHeld("rst");

    $display("[TB] directed: basic fetch, long latency, redirect-with-ack");
    doFetch(0, 32'h0010_0093);
    doFetch(5, 32'h0020_0113);
    doAbort(2, 32'h0000_0102, 1'b1);
    doFetch(1, 32'h0030_0193);
    checkOutput("redir_curr", curr_pc_fd, 32'h0000_0100);

    $display("[TB] directed: PC wrap, stall drop, stray ack");
    doJumpIdle(32'hFFFF_FFFC, 1'b0);
    doFetch(0, 32'h1234_5678);
    checkOutput("wrap_next", next_pc_fd, 32'h0);
    doStallOrStray(1'b0);
    doStallOrStray(1'b1);
    doFetch(2, 32'h8765_4321);
    checkOutput("wrap_follow_curr", curr_pc_fd, 32'h0);

    $display("[TB] directed: reset while busy, late ack");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("pre_rst_req", imem_req, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    modelReset();
    checkOutput("midrst_req", imem_req, 0);
    checkOutput("midrst_busy", fetch_busy, 0);
    checkHeld("midrst");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
    checkOutput("late_ack_valid", fetch_valid, 0);
    checkHeld("late_ack");
    doFetch(0, 32'h0000_0073);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0, 1: doFetch($urandom_range(0, 6), $urandom);
        2:    doAbort($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
        3:    doJumpIdle($urandom, 1'($urandom_range(0, 1)));
        default: doStallOrStray(1'($urandom_range(0, 1)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
